// File: rtl/solar_drive_pkg.sv
// Shared types and default constants for the solar tracker
// stepper drive.
package solar_drive_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STEP_HI = 2'd2,
    STEP_LO = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_N = 2'd0,
    CMD_E = 2'd1,
    CMD_S = 2'd2,
    CMD_W = 2'd3
  } cmd_e;

  localparam int unsigned HALF_CYC_DEF  = 4;
  localparam int unsigned SETUP_CYC_DEF = 2;
  localparam logic [7:0]  EL_MAX_DEF    = 8'd90;
  localparam logic [7:0]  AZ_MAX_DEF    = 8'd180;
  localparam logic [7:0]  EL_HOME_DEF   = 8'd45;
  localparam logic [7:0]  AZ_HOME_DEF   = 8'd90;

  function automatic logic cmd_is_az(cmd_e c);
    return (c == CMD_E) || (c == CMD_W);
  endfunction

endpackage

// File: rtl/solar_drive_if.sv
// Command and status bundle between the tracker controller
// and the stepper drive.
interface solar_drive_if;

  logic       mn;
  logic       me;
  logic       ms;
  logic       mw;
  logic       el_step;
  logic       el_dir;
  logic       az_step;
  logic       az_dir;
  logic [7:0] el_pos;
  logic [7:0] az_pos;
  logic       busy;
  logic       at_limit;

  modport master (
    output mn, me, ms, mw,
    input  el_step, el_dir, az_step, az_dir,
    input  el_pos, az_pos, busy, at_limit
  );

  modport slave (
    input  mn, me, ms, mw,
    output el_step, el_dir, az_step, az_dir,
    output el_pos, az_pos, busy, at_limit
  );

endinterface

// File: rtl/solar_axis.sv
// Saturating 8-bit position counter for one tracker axis,
// with limit flags for the drive FSM.
module solar_axis #(
  parameter logic [7:0] MAX  = 8'd90,
  parameter logic [7:0] HOME = 8'd45
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [7:0] pos_o,
  output logic       at_max_o,
  output logic       at_min_o
);

  logic [7:0] pos_q;
  logic [7:0] pos_d;

  always_comb begin
    pos_d = pos_q;
    if (inc_i && (pos_q < MAX)) begin
      pos_d = pos_q + 8'd1;
    end else if (dec_i && (pos_q != 8'd0)) begin
      pos_d = pos_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pos_q <= HOME;
    else     pos_q <= pos_d;
  end

  assign pos_o    = pos_q;
  assign at_max_o = (pos_q >= MAX);
  assign at_min_o = (pos_q == 8'd0);

endmodule

// File: rtl/solar_drive.sv
// Two-axis stepper drive: resolves move commands, sequences
// setup and step pulses, tracks positions within limits.
module solar_drive
  import solar_drive_pkg::*;
#(
  parameter int unsigned HALF_CYC  = HALF_CYC_DEF,
  parameter int unsigned SETUP_CYC = SETUP_CYC_DEF,
  parameter logic [7:0]  EL_MAX    = EL_MAX_DEF,
  parameter logic [7:0]  AZ_MAX    = AZ_MAX_DEF,
  parameter logic [7:0]  EL_HOME   = EL_HOME_DEF,
  parameter logic [7:0]  AZ_HOME   = AZ_HOME_DEF
) (
  input logic          clk,
  input logic          rst,
  solar_drive_if.slave bus
);

  localparam logic [7:0] HC_LAST = 8'(HALF_CYC - 1);
  localparam logic [7:0] SC_LAST = 8'(SETUP_CYC - 1);

  state_e     state_q;
  cmd_e       cmd_q;
  logic [7:0] cnt_q;
  logic       el_step_q;
  logic       az_step_q;
  logic       el_dir_q;
  logic       az_dir_q;
  logic       busy_q;
  logic       lim_q;

  cmd_e req_c;
  logic req_v;
  logic req_blk;
  logic el_max, el_min, az_max, az_min;
  logic hi_end;

  always_comb begin
    req_v = 1'b1;
    req_c = CMD_N;
    priority case (1'b1)
      bus.mn:  req_c = CMD_N;
      bus.me:  req_c = CMD_E;
      bus.ms:  req_c = CMD_S;
      bus.mw:  req_c = CMD_W;
      default: req_v = 1'b0;
    endcase
  end

  always_comb begin
    req_blk = 1'b0;
    unique case (req_c)
      CMD_N: req_blk = el_max;
      CMD_E: req_blk = az_max;
      CMD_S: req_blk = el_min;
      CMD_W: req_blk = az_min;
    endcase
  end

  // Position moves on the edge that ends the high half-pulse
  assign hi_end = (state_q == STEP_HI) && (cnt_q == HC_LAST);

  solar_axis #(.MAX(EL_MAX), .HOME(EL_HOME)) u_el (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (hi_end && (cmd_q == CMD_N)),
    .dec_i    (hi_end && (cmd_q == CMD_S)),
    .pos_o    (bus.el_pos),
    .at_max_o (el_max),
    .at_min_o (el_min)
  );

  solar_axis #(.MAX(AZ_MAX), .HOME(AZ_HOME)) u_az (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (hi_end && (cmd_q == CMD_E)),
    .dec_i    (hi_end && (cmd_q == CMD_W)),
    .pos_o    (bus.az_pos),
    .at_max_o (az_max),
    .at_min_o (az_min)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_q     <= CMD_N;
      cnt_q     <= 8'd0;
      el_step_q <= 1'b0;
      az_step_q <= 1'b0;
      el_dir_q  <= 1'b0;
      az_dir_q  <= 1'b0;
      busy_q    <= 1'b0;
      lim_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          lim_q <= req_v && req_blk;
          if (req_v && !req_blk) begin
            cmd_q   <= req_c;
            cnt_q   <= 8'd0;
            state_q <= SETUP;
            busy_q  <= 1'b1;
            unique case (req_c)
              CMD_N: el_dir_q <= 1'b1;
              CMD_S: el_dir_q <= 1'b0;
              CMD_E: az_dir_q <= 1'b1;
              CMD_W: az_dir_q <= 1'b0;
            endcase
          end
        end
        SETUP: begin
          if (!req_v || (req_c != cmd_q)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == SC_LAST) begin
            state_q   <= STEP_HI;
            cnt_q     <= 8'd0;
            el_step_q <= !cmd_is_az(cmd_q);
            az_step_q <= cmd_is_az(cmd_q);
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        STEP_HI: begin
          if (hi_end) begin
            state_q   <= STEP_LO;
            cnt_q     <= 8'd0;
            el_step_q <= 1'b0;
            az_step_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        STEP_LO: begin
          if (cnt_q == HC_LAST) begin
            cnt_q <= 8'd0;
            if (req_v && (req_c == cmd_q) && !req_blk) begin
              state_q   <= STEP_HI;
              el_step_q <= !cmd_is_az(cmd_q);
              az_step_q <= cmd_is_az(cmd_q);
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign bus.el_step  = el_step_q;
  assign bus.az_step  = az_step_q;
  assign bus.el_dir   = el_dir_q;
  assign bus.az_dir   = az_dir_q;
  assign bus.busy     = busy_q;
  assign bus.at_limit = lim_q;

endmodule

// File: tb/tb_solar_drive.sv
// Self-checking bench for solar_drive against a timeline
// model of held move commands.
module tb_solar_drive;

  localparam int S       = 2;
  localparam int H       = 4;
  localparam int EL_MAX  = 90;
  localparam int AZ_MAX  = 180;
  localparam int EL_HOME = 45;
  localparam int AZ_HOME = 90;

  logic clk = 1'b0;
  logic rst = 1'b1;

  solar_drive_if bus();

  solar_drive dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   m_el;
  int   m_az;
  logic m_el_dir;
  logic m_az_dir;

  task automatic set_cmd(input logic [3:0] mask);
    bus.mn = mask[0];
    bus.me = mask[1];
    bus.ms = mask[2];
    bus.mw = mask[3];
  endtask

  // mask bits: 0=mn 1=me 2=ms 3=mw; command held for edges 1..r
  task automatic test_hold(input logic [3:0] mask, input int r,
                           input string tag);
    int   c, room, n, eidle, t, p0, done;
    logic az, inc, hi;
    int   e_pos, e_el, e_az;
    logic e_busy, e_lim;
    c   = mask[0] ? 0 : mask[1] ? 1 : mask[2] ? 2 : 3;
    az  = (c == 1) || (c == 3);
    inc = (c < 2);
    p0  = az ? m_az : m_el;
    if (inc) room = (az ? AZ_MAX : EL_MAX) - p0;
    else     room = p0;
    n = (r >= S + 1) ? 1 + (r - S - 1) / (2 * H) : 0;
    if (n > room) n = room;
    eidle = (n > 0) ? S + 1 + 2 * H * n : 0;
    t = ((r + 1) > eidle ? r + 1 : eidle) + 1;
    if (room > 0) begin
      if (az) m_az_dir = inc;
      else    m_el_dir = inc;
    end
    set_cmd(mask);
    for (int e = 1; e <= t; e++) begin
      @(posedge clk);
      #1;
      hi   = 1'b0;
      done = 0;
      for (int k = 0; k < n; k++) begin
        if (e >= S + 1 + 2*H*k && e <= S + H + 2*H*k) hi = 1'b1;
        if (e >= S + H + 1 + 2*H*k) done++;
      end
      e_pos  = inc ? p0 + done : p0 - done;
      e_el   = az ? m_el : e_pos;
      e_az   = az ? e_pos : m_az;
      e_busy = (n > 0) ? (e < eidle) : ((room > 0) && (e <= r));
      e_lim  = (n == room) && (e > eidle) && (e <= r);
      checks += 8;
      if (bus.el_step !== (hi && !az)) begin
        errors++;
        $display("FAIL %s el_step e=%0d got %b want %b",
                 tag, e, bus.el_step, hi && !az);
      end
      if (bus.az_step !== (hi && az)) begin
        errors++;
        $display("FAIL %s az_step e=%0d got %b want %b",
                 tag, e, bus.az_step, hi && az);
      end
      if (bus.el_pos !== 8'(e_el)) begin
        errors++;
        $display("FAIL %s el_pos e=%0d got %0d want %0d",
                 tag, e, bus.el_pos, e_el);
      end
      if (bus.az_pos !== 8'(e_az)) begin
        errors++;
        $display("FAIL %s az_pos e=%0d got %0d want %0d",
                 tag, e, bus.az_pos, e_az);
      end
      if (bus.busy !== e_busy) begin
        errors++;
        $display("FAIL %s busy e=%0d got %b want %b",
                 tag, e, bus.busy, e_busy);
      end
      if (bus.at_limit !== e_lim) begin
        errors++;
        $display("FAIL %s at_limit e=%0d got %b want %b",
                 tag, e, bus.at_limit, e_lim);
      end
      if (bus.el_dir !== m_el_dir) begin
        errors++;
        $display("FAIL %s el_dir e=%0d got %b want %b",
                 tag, e, bus.el_dir, m_el_dir);
      end
      if (bus.az_dir !== m_az_dir) begin
        errors++;
        $display("FAIL %s az_dir e=%0d got %b want %b",
                 tag, e, bus.az_dir, m_az_dir);
      end
      if (e == r) set_cmd(4'b0000);
    end
    if (az) m_az = inc ? p0 + n : p0 - n;
    else    m_el = inc ? p0 + n : p0 - n;
  endtask

  task automatic test_reset();
    set_cmd(4'b0000);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_el = EL_HOME;
    m_az = AZ_HOME;
    m_el_dir = 1'b0;
    m_az_dir = 1'b0;
    checks++;
    if ({bus.el_step, bus.az_step, bus.el_dir, bus.az_dir,
         bus.busy, bus.at_limit} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000",
               {bus.el_step, bus.az_step, bus.el_dir,
                bus.az_dir, bus.busy, bus.at_limit});
    end
    checks++;
    if (bus.el_pos !== 8'(EL_HOME) || bus.az_pos !== 8'(AZ_HOME)) begin
      errors++;
      $display("FAIL reset_pos got %0d/%0d want %0d/%0d",
               bus.el_pos, bus.az_pos, EL_HOME, AZ_HOME);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_step();
    test_hold(4'b0001, S + 1, "single_n");
  endtask

  task automatic test_multi_step();
    test_hold(4'b0010, S + 1 + 2 * H * 2 + 1, "multi_e");
    checks++;
    if (bus.az_pos !== 8'(AZ_HOME + 3)) begin
      errors++;
      $display("FAIL multi_e_final az_pos got %0d want %0d",
               bus.az_pos, AZ_HOME + 3);
    end
  endtask

  task automatic test_priority();
    test_hold(4'b0101, S + 1, "prio_n_s");
    test_hold(4'b1010, S + 1, "prio_e_w");
  endtask

  task automatic test_release();
    test_hold(4'b1000, S + 2, "release_w");
  endtask

  task automatic test_abort();
    test_hold(4'b0100, S, "abort_s");
    test_hold(4'b0010, 1, "abort_e");
  endtask

  task automatic test_reset_mid_pulse();
    set_cmd(4'b0001);
    for (int e = 1; e <= S + 2; e++) begin
      @(posedge clk);
      #1;
      if (e == S + 1) begin
        checks++;
        if (bus.el_step !== 1'b1) begin
          errors++;
          $display("FAIL rst_mid pre el_step got %b want 1",
                   bus.el_step);
        end
        rst = 1'b1;
      end
    end
    checks++;
    if (bus.el_step !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid step/busy got %b/%b want 0/0",
               bus.el_step, bus.busy);
    end
    checks++;
    if (bus.el_pos !== 8'(EL_HOME) || bus.az_pos !== 8'(AZ_HOME)) begin
      errors++;
      $display("FAIL rst_mid pos got %0d/%0d want %0d/%0d",
               bus.el_pos, bus.az_pos, EL_HOME, AZ_HOME);
    end
    checks++;
    if (bus.el_dir !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid el_dir got %b want 0", bus.el_dir);
    end
    rst = 1'b0;
    set_cmd(4'b0000);
    m_el = EL_HOME;
    m_az = AZ_HOME;
    m_el_dir = 1'b0;
    m_az_dir = 1'b0;
  endtask

  task automatic test_limit();
    test_hold(4'b1000, S + 1 + 2 * H * AZ_HOME + 3, "limit_w");
    checks++;
    if (bus.az_pos !== 8'd0) begin
      errors++;
      $display("FAIL limit_w_final az_pos got %0d want 0",
               bus.az_pos);
    end
    test_hold(4'b1000, 5, "limit_w_held");
    test_hold(4'b0001, S + 1 + 2 * H * (EL_MAX - EL_HOME) + 4,
              "limit_n");
    test_hold(4'b0001, 3, "limit_n_held");
  endtask

  task automatic test_random();
    logic [3:0] mask;
    int         r;
    for (int i = 0; i < 30; i++) begin
      mask = 4'($urandom_range(1, 15));
      r    = $urandom_range(1, S + 1 + 2 * H * 4);
      test_hold(mask, r, "random");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    set_cmd(4'b0000);
    test_reset();
    test_single_step();
    test_multi_step();
    test_priority();
    test_release();
    test_abort();
    test_reset_mid_pulse();
    test_limit();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/solar_drive.md
SOLAR_DRIVE -- requirements
Module: solar_drive

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- HALF_CYC, 4: cycles per step-pulse half period (high and low), 1..255.
- SETUP_CYC, 2: direction-to-first-step setup cycles, 1..255.
- EL_MAX, 8'd90: maximum elevation position.
- AZ_MAX, 8'd180: maximum azimuth position.
- EL_HOME, 8'd45: elevation reset value.
- AZ_HOME, 8'd90: azimuth reset value.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all state changes on posedge clk.
- rst  input  1  reset, synchronous, active-high.
- mn, me, ms, mw  input  1 each  move-north/east/south/west commands from the tracker controller.
- el_step  output  1  elevation stepper pulse.
- el_dir  output  1  elevation direction; 1 = north (increasing).
- az_step  output  1  azimuth stepper pulse.
- az_dir  output  1  azimuth direction; 1 = east (increasing).
- el_pos  output  8  elevation position count.
- az_pos  output  8  azimuth position count.
- busy  output  1  high whenever the state is not IDLE.
- at_limit  output  1  current or last-requested move blocked by a position limit.

Function
REQ-003 The block SHALL register all outputs; no output SHALL depend combinationally on inputs.
REQ-004 The block SHALL resolve commands with priority mn > me > ms > mw; lower-priority commands are ignored while a higher one is asserted.
REQ-005 Axis mapping SHALL be: mn = elevation +1, ms = elevation -1, me = azimuth +1, mw = azimuth -1.
REQ-006 The FSM SHALL have states IDLE, SETUP, STEP_HI, STEP_LO.
REQ-007 In IDLE with a resolved command not blocked by a limit, the block SHALL latch axis and direction, drive the axis dir output, and enter SETUP on the next edge.
REQ-008 SETUP SHALL last exactly SETUP_CYC cycles, then the block SHALL enter STEP_HI.
REQ-009 STEP_HI SHALL drive the latched axis step output high for exactly HALF_CYC cycles; the other axis step output SHALL stay low.
REQ-010 The position SHALL update by ±1 on the edge leaving STEP_HI, then the block SHALL enter STEP_LO for exactly HALF_CYC cycles with step low.
REQ-011 At the end of STEP_LO, if the same resolved command is still asserted and the axis is not at its limit, the block SHALL return directly to STEP_HI with no SETUP; otherwise it SHALL return to IDLE.
REQ-012 A command dropped or changed mid-pulse SHALL NOT truncate the pulse; the current STEP_HI/STEP_LO pair always completes.
REQ-013 A command deasserted during SETUP SHALL abort to IDLE with no step and no position change.
REQ-014 Limits: an increment at position == MAX or a decrement at position == 0 is blocked; the block SHALL stay in IDLE and set at_limit.
REQ-015 at_limit SHALL clear on the first IDLE cycle with no command or with an unblocked command.
REQ-016 Positions SHALL saturate in the range 0..MAX and never wrap.
REQ-017 The dir outputs SHALL hold their last value when idle.

Reset
REQ-018 With rst high at posedge clk, the block SHALL set state=IDLE, el_step=az_step=0, el_dir=az_dir=0, busy=0, at_limit=0, el_pos=EL_HOME, az_pos=AZ_HOME, and clear all counters.
REQ-019 Reset asserted mid-pulse SHALL force step outputs low on that edge, and the interrupted step SHALL NOT be counted.

Structure
REQ-020 A shared package SHALL hold the FSM state encoding (IDLE=0, SETUP=1, STEP_HI=2, STEP_LO=3) and the default HALF_CYC, SETUP_CYC, EL/AZ MAX and HOME constants.
REQ-021 A single sub-module, solar_axis (one instance per axis), SHALL hold a saturating 8-bit position counter with inc/dec/limit outputs; the FSM and cycle counter SHALL stay in solar_drive.

Verification
REQ-022 Reset, then mn held for one full step: el_dir=1 on the first IDLE edge; el_step high 4 cycles after 2 setup cycles; el_pos 45->46 when el_step falls; az_step stays 0.
REQ-023 me held for 3 steps: az_step period is 8 cycles with no setup gap between pulses; az_pos 90->93; busy drops 1 cycle after the final STEP_LO.
REQ-024 mn and ms asserted together: only north moves; mw released after 1 cycle of STEP_HI: the full 4-cycle pulse completes, then IDLE; az_pos decrements by 1.
REQ-025 Decrement az_pos to 0, then hold mw: at_limit=1, no az_step, busy=0; release mw -> at_limit=0.
REQ-026 rst pulsed on cycle 2 of STEP_HI: el_step=0 on that edge; el_pos=45 and az_pos=90 after reset.
